// File: rtl/gpu_arith_pkg.sv
// Shared arithmetic types for the GPU raster/interpolation iterative units
// (multiply-add FSM states and the iteration-counter width helper).
package gpu_arith_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUSY = 2'd1,
    MA_DONE = 2'd2
  } mul_add_state_t;

  // Counter must hold 0..width inclusive.
  function automatic int ma_count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/unsigned_multiply_add_datapath.sv
// Shift-add datapath for unsigned_multiply_add: accumulator, shifting
// multiplicand/multiplier and iteration counter, one iteration per step.
module multiply_add_datapath
  import gpu_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_c,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_mplier_zero_next,
  output logic               o_last_iter
);

  localparam int CW = ma_count_w(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_acc    <= {{WIDTH{1'b0}}, i_c};
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      // a*b+c never exceeds 2*WIDTH bits, so the carry-out is dropped.
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_acc              = r_acc;
  assign o_mplier_zero_next = (r_mplier[WIDTH-1:1] == '0);
  assign o_last_iter        = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/unsigned_multiply_add.sv
// Sequential unsigned multiply-add o_result = a*b + c with start/ready/valid
// handshake. Define UNSIGNED_MULTIPLY_ADD_EARLY_EXIT_EN to stop after the top set bit of b.
module unsigned_multiply_add
  import gpu_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_c,
  output logic               o_ready,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_result
);

`ifdef UNSIGNED_MULTIPLY_ADD_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_add_state_t     r_state;
  mul_add_state_t     w_state_next;
  logic               w_load;
  logic               w_step;
  logic               w_exit;
  logic               w_skip;
  logic               w_mplier_zero_next;
  logic               w_last_iter;
  logic [2*WIDTH-1:0] w_acc;

  assign w_load = (r_state == MA_IDLE) && i_start;
  assign w_step = (r_state == MA_BUSY);
  assign w_exit = EARLY_EXIT ? w_mplier_zero_next : w_last_iter;
  assign w_skip = EARLY_EXIT && (i_b == '0);

  multiply_add_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_load             (w_load),
    .i_step             (w_step),
    .i_a                (i_a),
    .i_b                (i_b),
    .i_c                (i_c),
    .o_acc              (w_acc),
    .o_mplier_zero_next (w_mplier_zero_next),
    .o_last_iter        (w_last_iter)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= MA_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MA_IDLE: if (i_start) w_state_next = w_skip ? MA_DONE : MA_BUSY;
      MA_BUSY: if (w_exit)  w_state_next = MA_DONE;
      MA_DONE:              w_state_next = MA_IDLE;
      default:              w_state_next = MA_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == MA_IDLE);
    o_valid = (r_state == MA_DONE);
  end

  // Accumulator is only rewritten by a load, so the result holds until the next start.
  assign o_result = w_acc;

endmodule

// File: tb/tb_unsigned_multiply_add.sv
// Self-checking bench for unsigned_multiply_add (WIDTH=16): directed vector
// table plus hand-written reset/overlap/back-to-back sequences and random ops.
module tb_unsigned_multiply_add;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b, c;
  logic          ready, valid;
  logic [2*W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  unsigned_multiply_add #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .i_c      (c),
    .o_ready  (ready),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] bv);
`ifdef UNSIGNED_MULTIPLY_ADD_EARLY_EXIT_EN
    int k = 0;
    for (int i = 0; i < W; i++) if (bv[i]) k = i + 1;
    return k;
`else
    return W;
`endif
  endfunction

  // Starts an op from IDLE and waits (bounded) for o_valid; lat counts edges after E0.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                        output logic [2*W-1:0] res, output int lat);
    a = va; b = vb; c = vc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  // Full transaction check: latency, result, one-tick valid, ready after, result held.
  task automatic do_checked(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [W-1:0] vc, input logic [2*W-1:0] exp);
    logic [2*W-1:0] res;
    int lat;
    check({name, " ready_before"}, 64'(ready), 64'd1);
    run_op(va, vb, vc, res, lat);
    check({name, " result"}, 64'(res), 64'(exp));
    check({name, " latency"}, 64'(lat), 64'(exp_latency(vb)));
    tick();
    check({name, " valid_one_tick"}, 64'(valid), 64'd0);
    check({name, " ready_after"}, 64'(ready), 64'd1);
    check({name, " result_held"}, 64'(result), 64'(exp));
  endtask

  initial begin
    logic [2*W-1:0] res;
    int lat;
    int pulses;

    vecs[0] = '{16'd3,    16'd5,    16'd7,    32'h0000_0016};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0001, 16'h8000, 16'h0000, 32'h0000_8000};
    vecs[4] = '{16'h0004, 16'h0001, 16'h0000, 32'h0000_0004};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0009, 32'h0000_0009};
    vecs[6] = '{16'h1234, 16'h5678, 16'h9ABC, 32'h0626_9B1C};
    vecs[7] = '{16'hFFFF, 16'h0001, 16'h0000, 32'h0000_FFFF};
    vecs[8] = '{16'h0002, 16'h0003, 16'h0001, 32'h0000_0007};
    vecs[9] = '{16'h8000, 16'h8000, 16'hFFFF, 32'h4000_FFFF};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    tick(); tick();
    check("reset ready", 64'(ready), 64'd1);
    check("reset valid", 64'(valid), 64'd0);
    check("reset result", 64'(result), 64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; a = 16'd9; b = 16'd9; c = 16'd9;
    tick();
    start = 1'b0; reset = 1'b0;
    check("reset_vs_start ready", 64'(ready), 64'd1);
    check("reset_vs_start result", 64'(result), 64'd0);

    for (int i = 0; i < 10; i++)
      do_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);

    // Reset at cycle 8 of an op aborts it: IDLE next tick, cleared result, no valid.
    a = 16'd100; b = 16'hFFFF; c = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort busy", 64'(ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort ready", 64'(ready), 64'd1);
    check("abort result", 64'(result), 64'd0);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (valid) pulses++;
      tick();
    end
    check("abort no_valid", 64'(pulses), 64'd0);
    check("abort result_stays", 64'(result), 64'd0);

    // Start pulse with new operands while busy must be ignored.
    a = 16'd2; b = 16'd3; c = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a = 16'd1; b = 16'd1; c = 16'd0; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hAAAA; b = 16'h5555; c = 16'h1111;
    pulses = 0;
    res = '0;
    for (int i = 0; i < 30; i++) begin
      if (valid) begin
        pulses++;
        res = result;
      end
      if (!(valid || ready)) tick();
      else if (valid) tick();
      else break;
    end
    check("overlap single_valid", 64'(pulses), 64'd1);
    check("overlap result", 64'(res), 64'd7);
    check("overlap ready", 64'(ready), 64'd1);
    // Restart on the ready tick.
    run_op(16'd1, 16'd1, 16'd0, res, lat);
    check("restart result", 64'(res), 64'd1);
    check("restart latency", 64'(lat), 64'(exp_latency(16'd1)));
    tick();

    // Random operations against a*b+c, issued on the first ready tick.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb, rc;
      logic [2*W-1:0] exp;
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      exp = (2*W)'(ra) * (2*W)'(rb) + (2*W)'(rc);
      run_op(ra, rb, rc, res, lat);
      check($sformatf("rand%0d result", i), 64'(res), 64'(exp));
      if (lat != exp_latency(rb)) check($sformatf("rand%0d latency", i), 64'(lat), 64'(exp_latency(rb)));
      tick();
      check($sformatf("rand%0d one_tick", i), 64'({valid, ready}), 64'b01);
      check($sformatf("rand%0d held", i), 64'(result), 64'(exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
